// File: rtl/ctu_clsp_cmpgif_seq_if.sv
// Signal bundle between the CTU clsp cluster sequencer and the CMP-domain
// global-signal / clock-enable interface block.
interface ctu_clsp_cmpgif_seq_if #(
    parameter int NCH   = 22,
    parameter int NSYNC = 4
);
    logic             start_clk_cl;
    logic             grst_cl_l;
    logic             dbginit_cl_l;
    logic [NSYNC-1:0] sync_cl;
    logic [NCH-1:0]   cken_cg;
    logic             stagger_en;

    logic             grst_out_l;
    logic             dbginit_out_l;
    logic [NSYNC-1:0] sync_out;
    logic [NCH-1:0]   cken;
    logic             cken_busy;

    modport master (
        output start_clk_cl, grst_cl_l, dbginit_cl_l, sync_cl, cken_cg, stagger_en,
        input  grst_out_l, dbginit_out_l, sync_out, cken, cken_busy
    );

    modport slave (
        input  start_clk_cl, grst_cl_l, dbginit_cl_l, sync_cl, cken_cg, stagger_en,
        output grst_out_l, dbginit_out_l, sync_out, cken, cken_busy
    );
endinterface

// File: rtl/ctu_clsp_cmpgif_seq.sv
// CMP-domain retiming of global reset / debug-init / sync pulses, plus per-cluster
// clock enables with immediate turn-off and optionally staggered turn-on.
module ctu_clsp_cmpgif_seq #(
    parameter int NCH       = 22,
    parameter int NSYNC     = 4,
    parameter int SYNC_PIPE = 1,
    parameter int STAGGER   = 4
) (
    input  logic                  cmp_gclk,
    input  logic                  cmp_grst_l,
    ctu_clsp_cmpgif_seq_if.slave  bus
);
    localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             start_clk_cg_q, start_clk_cg_d;
    logic             grst_out_l_q, grst_out_l_d;
    logic             dbginit_out_l_q, dbginit_out_l_d;
    logic [NSYNC-1:0] sync_q [SYNC_PIPE];
    logic [NSYNC-1:0] sync_d [SYNC_PIPE];
    logic [NCH-1:0]   tgt_q, tgt_d;
    logic [NCH-1:0]   cken_q, cken_d;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   lowest;

    // NOTE: every variable gets a default at the top of the block so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        start_clk_cg_d  = bus.start_clk_cl;
        grst_out_l_d    = bus.grst_cl_l & start_clk_cg_q;
        dbginit_out_l_d = bus.dbginit_cl_l & start_clk_cg_q;
        sync_d[0]       = bus.sync_cl;
        for (int i = 1; i < SYNC_PIPE; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        tgt_d   = bus.cken_cg;
        pending = tgt_q & ~cken_q & {NCH{start_clk_cg_q}};
        lowest  = pending & (~pending + NCH'(1));

        // Turn-off is unconditional: any enabled channel whose target dropped clears.
        cken_d  = cken_q & tgt_q;
        state_d = state_q;
        gap_d   = gap_q;

        if (!start_clk_cg_q) begin
            cken_d  = '0;
            state_d = ST_IDLE;
            gap_d   = '0;
        end else if (!bus.stagger_en) begin
            cken_d  = cken_d | pending;
            state_d = ST_IDLE;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pending != '0) begin
                        cken_d = cken_d | lowest;
                        if (STAGGER > 1) begin
                            gap_d   = GW'(STAGGER - 1);
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_d = gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge cmp_gclk) begin
        if (!cmp_grst_l) begin
            state_q         <= ST_IDLE;
            gap_q           <= '0;
            start_clk_cg_q  <= 1'b0;
            grst_out_l_q    <= 1'b0;
            dbginit_out_l_q <= 1'b0;
            tgt_q           <= '0;
            cken_q          <= '0;
            for (int i = 0; i < SYNC_PIPE; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            gap_q           <= gap_d;
            start_clk_cg_q  <= start_clk_cg_d;
            grst_out_l_q    <= grst_out_l_d;
            dbginit_out_l_q <= dbginit_out_l_d;
            tgt_q           <= tgt_d;
            cken_q          <= cken_d;
            for (int i = 0; i < SYNC_PIPE; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign bus.grst_out_l    = grst_out_l_q;
    assign bus.dbginit_out_l = dbginit_out_l_q;
    assign bus.sync_out      = sync_q[SYNC_PIPE-1];
    assign bus.cken          = cken_q;
    assign bus.cken_busy     = (pending != '0) || (state_q == ST_GAP);
endmodule

// File: tb/tb_ctu_clsp_cmpgif_seq.sv
// Scoreboarded bench: a timestamp-based reference model predicts every cycle's
// outputs; a negedge monitor compares them against the DUT.
module tb_ctu_clsp_cmpgif_seq;
    localparam int NCH       = 22;
    localparam int NSYNC     = 4;
    localparam int SYNC_PIPE = 2;
    localparam int STAGGER   = 4;

    typedef struct {
        logic             grst;
        logic             dbg;
        logic [NSYNC-1:0] sync;
        logic [NCH-1:0]   cken;
        logic             busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctu_clsp_cmpgif_seq_if #(.NCH(NCH), .NSYNC(NSYNC)) bus ();

    ctu_clsp_cmpgif_seq #(
        .NCH(NCH), .NSYNC(NSYNC), .SYNC_PIPE(SYNC_PIPE), .STAGGER(STAGGER)
    ) dut (
        .cmp_gclk   (clk),
        .cmp_grst_l (rst_n),
        .bus        (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: turn-on rate limit expressed as "edge of last staggered
    // turn-on", not as a state machine.
    logic             m_start, m_grst, m_dbg;
    logic [NCH-1:0]   m_tgt, m_cken;
    logic [NSYNC-1:0] m_sync [SYNC_PIPE];
    int               last_on    = 0;
    bit               last_valid = 0;
    int               edge_n     = 0;

    task automatic model_edge();
        logic [NCH-1:0] pend, nxt;
        exp_t e;
        if (!rst_n) begin
            m_start = 0; m_grst = 0; m_dbg = 0; m_tgt = '0; m_cken = '0;
            for (int i = 0; i < SYNC_PIPE; i++) m_sync[i] = '0;
            last_valid = 0;
        end else begin
            pend = m_tgt & ~m_cken & {NCH{m_start}};
            if (!m_start) begin
                nxt = '0;
                last_valid = 0;
            end else begin
                nxt = m_cken & m_tgt;
                if (!bus.stagger_en) begin
                    nxt = nxt | pend;
                    last_valid = 0;
                end else if (pend != '0 && (!last_valid || edge_n - last_on >= STAGGER)) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (pend[i]) begin
                            nxt[i] = 1'b1;
                            break;
                        end
                    end
                    last_on    = edge_n;
                    last_valid = 1;
                end
            end
            for (int i = SYNC_PIPE - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = bus.sync_cl;
            m_grst  = bus.grst_cl_l & m_start;
            m_dbg   = bus.dbginit_cl_l & m_start;
            m_start = bus.start_clk_cl;
            m_tgt   = bus.cken_cg;
            m_cken  = nxt;
        end
        e.grst = m_grst;
        e.dbg  = m_dbg;
        e.sync = m_sync[SYNC_PIPE-1];
        e.cken = m_cken;
        e.busy = ((m_tgt & ~m_cken & {NCH{m_start}}) != '0) ||
                 (last_valid && (edge_n - last_on < STAGGER - 1));
        exp_q.push_back(e);
        edge_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grst_out_l",    bus.grst_out_l,    e.grst);
                check("dbginit_out_l", bus.dbginit_out_l, e.dbg);
                check("sync_out",      bus.sync_out,      e.sync);
                check("cken",          bus.cken,          e.cken);
                check("cken_busy",     bus.cken_busy,     e.busy);
            end
        end
    end

    initial begin : stimulus
        int idx;
        bus.start_clk_cl = 1; bus.grst_cl_l = 1; bus.dbginit_cl_l = 1;
        bus.sync_cl = '1; bus.cken_cg = '1; bus.stagger_en = 1;

        // Reset held with all inputs high.
        ticks(3);
        check("rst_grst",  bus.grst_out_l, 0);
        check("rst_dbg",   bus.dbginit_out_l, 0);
        check("rst_sync",  bus.sync_out, 0);
        check("rst_cken",  bus.cken, 0);
        check("rst_busy",  bus.cken_busy, 0);
        rst_n = 1;
        tick(); check("rel_grst_c1", bus.grst_out_l, 0);
        tick(); check("rel_grst_c2", bus.grst_out_l, 1);

        bus.sync_cl = '0; bus.cken_cg = '0;
        ticks(8);

        // Staggered turn-on of four channels.
        bus.cken_cg = 22'hF;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 2)  check("stg_c2",  bus.cken, 22'h1);
            if (c == 5)  check("stg_c5",  bus.cken, 22'h1);
            if (c == 6)  check("stg_c6",  bus.cken, 22'h3);
            if (c == 10) check("stg_c10", bus.cken, 22'h7);
            if (c == 14) check("stg_c14", bus.cken, 22'hF);
            if (c == 16) check("stg_busy16", bus.cken_busy, 1);
            if (c == 17) check("stg_busy17", bus.cken_busy, 0);
        end
        bus.cken_cg = '0; ticks(8);

        // Mid-sequence turn-off.
        bus.cken_cg = 22'hF;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 7) begin
                check("mid_c7", bus.cken, 22'h3);
                bus.cken_cg = 22'h7;
            end
            if (c == 8) bus.cken_cg = '0;
            if (c == 9)  check("mid_c9",  bus.cken, 22'h3);
            if (c == 10) check("mid_c10", bus.cken, 22'h0);
        end
        ticks(8);

        // stagger_en falls during the gap.
        bus.cken_cg = 22'hF;
        ticks(2); check("sfall_c2", bus.cken, 22'h1);
        tick(); bus.stagger_en = 0;
        tick(); check("sfall_c4", bus.cken, 22'hF);
        bus.cken_cg = '0; ticks(3); bus.stagger_en = 1; ticks(4);

        // start_clk_cl drop with every channel on.
        bus.stagger_en = 0; bus.cken_cg = '1;
        ticks(3); check("all_on", bus.cken, 22'h3FFFFF);
        bus.start_clk_cl = 0;
        tick(); check("sdrop_c1_cken", bus.cken, 22'h3FFFFF);
        tick(); check("sdrop_c2_cken", bus.cken, 0);
        check("sdrop_c2_grst", bus.grst_out_l, 0);
        bus.start_clk_cl = 1; bus.cken_cg = '0; ticks(4);

        // One-cycle sync pulse through the retiming pipe.
        bus.sync_cl = 4'b0100;
        tick(); bus.sync_cl = '0; check("sync_c1", bus.sync_out, 4'b0000);
        tick(); check("sync_c2", bus.sync_out, 4'b0100);
        tick(); check("sync_c3", bus.sync_out, 4'b0000);
        bus.stagger_en = 1; ticks(4);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) bus.stagger_en = ~bus.stagger_en;
            if (bus.start_clk_cl ? ($urandom_range(0, 119) == 0) : ($urandom_range(0, 5) == 0))
                bus.start_clk_cl = ~bus.start_clk_cl;
            if ($urandom_range(0, 15) == 0) bus.grst_cl_l = ~bus.grst_cl_l;
            if ($urandom_range(0, 15) == 0) bus.dbginit_cl_l = ~bus.dbginit_cl_l;
            bus.sync_cl = NSYNC'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, NCH - 1);
                bus.cken_cg[idx] = ~bus.cken_cg[idx];
            end
            if ($urandom_range(0, 79) == 0) bus.cken_cg = '0;
            if ($urandom_range(0, 79) == 0) bus.cken_cg = NCH'($urandom);
            tick();
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
